// File: rtl/ex_mem_pkg.sv
// EX/MEM stage shared types: entry bundle, occupancy states,
// exception bit positions and write-masking helper.
package ex_mem_pkg;

  localparam int EXC_OVERFLOW_BIT = 11;
  localparam int EXC_TRAP_BIT     = 10;
  localparam int ENTRY_ADDR_W     = 5;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic [63:0]             wdata;
    logic [31:0]             exception;
    logic [31:0]             pc;
    logic                    in_delay_slot;
    logic                    wreg;
    logic [ENTRY_ADDR_W-1:0] waddr;
    logic                    whilo;
  } ex_mem_entry_t;

  // Excepting instructions lose both writes; r0 never gets a GPR write.
  function automatic ex_mem_entry_t mask_writes(
    input ex_mem_entry_t e,
    input logic [31:0]   mask
  );
    ex_mem_entry_t r;
    logic          exc;
    r   = e;
    exc = |(e.exception & mask);
    if (exc) begin
      r.wreg  = 1'b0;
      r.whilo = 1'b0;
    end
    if (e.waddr == '0) r.wreg = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// Main entry drives MEM; skid entry holds one extra result.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] EXC_MASK = 32'hFFFF_FF00
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  input  logic              alu_ok_i,
  output logic              ex_ready_o,
  output logic              stall_req_o,
  input  logic [63:0]       alu_wdata_i,
  input  logic [31:0]       exception_type_i,
  input  logic [31:0]       pc_i,
  input  logic              in_delay_slot_i,
  input  logic              wreg_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic              whilo_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [63:0]       mem_wdata_o,
  output logic [31:0]       mem_exception_o,
  output logic [31:0]       mem_pc_o,
  output logic              mem_in_delay_slot_o,
  output logic              mem_wreg_o,
  output logic [ADDR_W-1:0] mem_waddr_o,
  output logic              mem_whilo_o
);

  state_t        state_q;
  ex_mem_entry_t main_q;
  ex_mem_entry_t skid_q;
  ex_mem_entry_t in_entry;
  logic          accept;
  logic          pop;

  // Build the incoming entry with writes already masked.
  always_comb begin
    in_entry = mask_writes('{
      wdata:         alu_wdata_i,
      exception:     exception_type_i,
      pc:            pc_i,
      in_delay_slot: in_delay_slot_i,
      wreg:          wreg_i,
      waddr:         ENTRY_ADDR_W'(waddr_i),
      whilo:         whilo_i
    }, EXC_MASK);
  end

  assign accept = ex_valid_i & alu_ok_i
                & ex_ready_o & ~flush_i;
  assign pop    = mem_valid_o & mem_ready_i;

  assign stall_req_o = ex_valid_i
                     & (~alu_ok_i | ~ex_ready_o);

  assign mem_valid_o         = (state_q != EMPTY);
  assign mem_wdata_o         = main_q.wdata;
  assign mem_exception_o     = main_q.exception;
  assign mem_pc_o            = main_q.pc;
  assign mem_in_delay_slot_o = main_q.in_delay_slot;
  assign mem_wreg_o          = main_q.wreg;
  assign mem_waddr_o         = ADDR_W'(main_q.waddr);
  assign mem_whilo_o         = main_q.whilo;

  // Occupancy FSM; ex_ready is registered as "not in TWO".
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= EMPTY;
      ex_ready_o <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush_i) begin
      state_q    <= EMPTY;
      ex_ready_o <= 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_entry;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q     <= in_entry;
            state_q    <= TWO;
            ex_ready_o <= 1'b0;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            ex_ready_o <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          ex_ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
